// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch and load/store unit.
// Splits word/half/byte accesses into single-byte RAM cycles.
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        flush,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic        last_grant_q, last_grant_d;
  logic        src_q, src_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic [31:0] byte_addr;
  logic [31:0] wshift;
  logic [2:0]  len_n;
  logic        pick_if;
  logic        stall;
  logic [5:0]  rd_sh;

  assign byte_addr = addr_q + 32'(cnt_q);
  assign wshift    = wdata_q >> {cnt_q, 3'b000};
  assign rd_sh     = {cnt_q - 3'd1, 3'b000};
  assign stall     = io_buffer_full && (addr_q[17:16] == 2'b11);
  assign len_n     = (ls_len == 2'd0) ? 3'd1 :
                     (ls_len == 2'd1) ? 3'd2 : 3'd4;
  // last_grant_q = 1 means the LSB was served last
  assign pick_if   = if_req && !flush && (!ls_req || last_grant_q);

  // Arbitration, byte sequencing and RAM-side drive
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    if_done_d    = 1'b0;
    ls_done_d    = 1'b0;
    if_data_d    = if_data_q;
    ls_rdata_d   = ls_rdata_q;
    mem_a        = 32'd0;
    mem_dout     = 8'd0;
    mem_wr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        buf_d = 32'd0;
        if (pick_if) begin
          state_d      = READ;
          src_d        = 1'b0;
          addr_d       = if_addr;
          n_d          = 3'd4;
          last_grant_d = 1'b0;
        end else if (ls_req) begin
          state_d      = ls_wr ? WRITE : READ;
          src_d        = 1'b1;
          addr_d       = ls_addr;
          n_d          = len_n;
          wdata_d      = ls_wdata;
          last_grant_d = 1'b1;
        end
      end
      READ: begin
        if (!src_q && flush) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q < n_q) mem_a = byte_addr;
          if (cnt_q != 3'd0)
            buf_d = buf_q | (32'(mem_din) << rd_sh);
          if (cnt_q == n_q) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (src_q) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = buf_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      WRITE: begin
        mem_a    = byte_addr;
        mem_dout = wshift[7:0];
        if (!stall) begin
          mem_wr = 1'b1;
          if (cnt_q == n_q - 3'd1) begin
            state_d   = IDLE;
            cnt_d     = 3'd0;
            ls_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      n_q          <= 3'd0;
      last_grant_q <= 1'b0;
      src_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      buf_q        <= 32'd0;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
      if_data_q    <= 32'd0;
      ls_rdata_q   <= 32'd0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      if_done_q    <= if_done_d;
      ls_done_q    <= ls_done_d;
      if_data_q    <= if_data_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk_in, in, 1, the single clock.
- rst_in, in, 1, asynchronous active-low reset.
- rdy_in, in, 1, global pause when low.
REQ-002 SHALL have RAM-side ports:
- mem_din, in, 8, read byte, valid the cycle after its address.
- mem_dout, out, 8, write byte.
- mem_a, out, 32, byte address.
- mem_wr, out, 1, 1 = write this cycle.
- io_buffer_full, in, 1, UART buffer full.
REQ-003 SHALL have fetch-side ports:
- if_req, in, 1, request.
- if_addr, in, 32, word address.
- if_done, out, 1, one-cycle done pulse.
- if_data, out, 32, fetched word.
- flush, in, 1, mispredict/JALR redirect.
REQ-004 SHALL have LSB-side ports:
- ls_req, in, 1, request.
- ls_wr, in, 1, 1 = store.
- ls_len, in, 2, 0 = byte, 1 = half, 2 = word.
- ls_addr, in, 32, address.
- ls_wdata, in, 32, store data.
- ls_done, out, 1, one-cycle done pulse.
- ls_rdata, out, 32, load data.

Function
REQ-005 SHALL implement states IDLE, READ and WRITE, plus a 3-bit byte counter cnt and a last_grant bit.
REQ-006 Requesters SHALL hold req and operands stable until their done pulse; requests are sampled only in IDLE.
REQ-007 If exactly one request is present in IDLE, it SHALL be granted; if both are present, the requester not named by last_grant SHALL win; last_grant updates on every grant.
REQ-008 A fetch grant SHALL be a READ of 4 bytes at if_addr; an LSB grant SHALL be a READ or WRITE (per ls_wr) of N = 1, 2 or 4 bytes (per ls_len) at ls_addr.
REQ-009 READ: in access cycle k (k = 0..N-1) mem_a SHALL be addr+k with mem_wr = 0; the byte on mem_din in cycle k+1 SHALL be stored to result bits [8k+7:8k] (little-endian); unused upper bits are 0 and no sign extension is performed.
REQ-010 READ completion: the done pulse with data valid SHALL occur N+2 cycles after the granting IDLE cycle; state returns to IDLE in the done cycle.
REQ-011 WRITE: in cycle k, mem_a SHALL be addr+k, mem_dout = ls_wdata[8k+7:8k] and mem_wr = 1; ls_done SHALL pulse N+1 cycles after the grant cycle.
REQ-012 WRITE stall: while io_buffer_full = 1 and addr[17:16] = 2'b11, mem_wr SHALL be 0 and cnt SHALL hold; the step resumes when io_buffer_full falls.
REQ-013 flush = 1 during a fetch READ SHALL abort it: no if_done, IDLE next cycle, mem_wr = 0. flush in IDLE SHALL block a fetch grant that cycle. flush SHALL never affect LSB accesses.
REQ-014 In IDLE, mem_a, mem_dout and mem_wr SHALL be 0.
REQ-015 Done pulses SHALL last exactly one cycle; if_data and ls_rdata hold their value until the next done.
REQ-016 rdy_in = 0 SHALL freeze all state and outputs (done pulses included); operation continues unchanged when rdy_in returns to 1.
REQ-017 A new grant SHALL be possible in the cycle a done pulse is high; back-to-back accesses have no extra idle cycle.

Reset
REQ-018 rst_in = 0 SHALL asynchronously force state = IDLE, cnt = 0, last_grant = IF (so the LSB wins the first tie), and all outputs to 0.
REQ-019 Reset mid-access SHALL discard the access with no done pulse; after release the arbiter re-arbitrates from IDLE.

Verification
REQ-020 Fetch word read: if_req = 1 with if_addr = 0x100 and RAM bytes 0x13,0x05,0x10,0x00 -> mem_a = 0x100..0x103 on consecutive cycles; if_done in cycle 6 with if_data = 0x00100513.
REQ-021 Tie: if_req and ls_req (byte read, 0x2000) rise together after reset -> the LSB is served first; if_done follows with no idle gap; a second tie goes to the fetch side.
REQ-022 Half store: ls_wdata = 0xABCD at 0x400 -> mem_wr = 1 for 2 cycles, bytes 0xCD then 0xAB at addresses 0x400 and 0x401; ls_done in cycle 3.
REQ-023 I/O stall: byte store to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write; ls_done is delayed by 3 cycles.
REQ-024 Flush during fetch: flush at access cycle 2 -> no if_done and IDLE next cycle; a pending ls_req is granted immediately afterwards.
REQ-025 Reset/pause: rst_in low mid-store -> outputs 0 at once with no ls_done; rdy_in low for 5 cycles during a read -> done is delayed by exactly 5 cycles with correct data.
